// File: rtl/data_sel_pkg.sv
// Shared constants for the data select / arbitration block.
package data_sel_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NCH.
module rr_pick #(
    parameter int NCH   = 4,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] gnt,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        gnt = '0;
        any = |req;
        idx = 0;
        // Walk the offsets from farthest to nearest so the nearest requester wins.
        for (int unsigned off = NCH; off >= 1; off--) begin
            idx = (int'(last) + off) % NCH;
            if (req[idx[SEL_W-1:0]]) begin
                gnt = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/data_select_arb.sv
// Selects one of NCH valid/ready channels (manual or round-robin) into a registered output slot.
module data_select_arb
    import data_sel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mode,
    input  logic [SEL_W-1:0]     i_ctrl,
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [NCH-1:0]       i_valid,
    output logic [NCH-1:0]       o_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [SEL_W-1:0]     o_chan,
    output logic                 o_valid,
    input  logic                 i_ready
);

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic [SEL_W-1:0] o_chan_q, o_chan_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic [SEL_W-1:0] rr_gnt;
    logic             rr_any;
    logic [SEL_W-1:0] gnt;
    logic             gnt_ok;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req  (i_valid),
        .last (last_q),
        .gnt  (rr_gnt),
        .any  (rr_any)
    );

    always_comb begin
        space  = !o_valid_q || i_ready;
        gnt    = '0;
        gnt_ok = 1'b0;
        if (mode_e'(i_mode) == MODE_RR) begin
            gnt    = rr_gnt;
            gnt_ok = rr_any;
        end else begin
            gnt = i_ctrl;
            // Out-of-range manual selects (non-power-of-two NCH) never grant.
            for (int unsigned k = 0; k < NCH; k++) begin
                if (i_ctrl == SEL_W'(k)) begin
                    gnt_ok = i_valid[k];
                end
            end
        end
        accept = !i_rst && space && gnt_ok;

        o_ready  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (gnt == SEL_W'(k)) begin
                o_ready[k] = accept;
                sel_data   = i_data[k*WIDTH +: WIDTH];
            end
        end

        o_valid_d = space ? gnt_ok : o_valid_q;
        o_data_d  = accept ? sel_data : o_data_q;
        o_chan_d  = accept ? gnt : o_chan_q;
        last_d    = accept ? gnt : last_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_chan_q  <= '0;
            last_q    <= SEL_W'(NCH - 1);
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_chan_q  <= o_chan_d;
            last_q    <= last_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_chan  = o_chan_q;

endmodule

// File: tb/tb_data_select_arb.sv
// Self-checking bench for data_select_arb: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_data_select_arb;
    import data_sel_pkg::*;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SEL_W-1:0]     ctrl;
    logic [NCH*WIDTH-1:0] data;
    logic [NCH-1:0]       valid;
    logic [NCH-1:0]       o_ready;
    logic [WIDTH-1:0]     o_data;
    logic [SEL_W-1:0]     o_chan;
    logic                 o_valid;
    logic                 rdy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_chan  = 0;
    int               m_last  = NCH - 1;

    logic [WIDTH-1:0] held;

    always #5 clk = ~clk;

    data_select_arb #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_mode  (mode),
        .i_ctrl  (ctrl),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_chan  (o_chan),
        .o_valid (o_valid),
        .i_ready (rdy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] chan_data(input int k);
        logic [NCH*WIDTH-1:0] d;
        d = data;
        return d[k*WIDTH +: WIDTH];
    endfunction

    // One clock: check combinational o_ready, advance model at the edge, then check registered outputs.
    task automatic cycle(input string tag);
        int  g;
        bit  ok;
        bit  space;
        logic [NCH-1:0] er;
        #3;
        space = !m_valid || rdy;
        ok = 1'b0;
        g  = 0;
        if (mode == MODE_MANUAL) begin
            g  = int'(ctrl);
            ok = (g < NCH) && valid[g];
        end else begin
            for (int off = 1; off <= NCH; off++) begin
                int k;
                k = (m_last + off) % NCH;
                if (!ok && valid[k]) begin
                    g  = k;
                    ok = 1'b1;
                end
            end
        end
        er = (!rst && space && ok) ? (NCH'(1) << g) : '0;
        check_eq({tag, ".ready"}, 32'(o_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_last  = NCH - 1;
        end else if (space) begin
            if (ok) begin
                m_valid = 1'b1;
                m_data  = chan_data(g);
                m_chan  = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_eq({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        check_eq({tag, ".data"},  32'(o_data),  32'(m_data));
        check_eq({tag, ".chan"},  32'(o_chan),  32'(m_chan));
    endtask

    initial begin
        rst   = 1'b1;
        mode  = MODE_MANUAL;
        ctrl  = '0;
        data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        valid = 4'b1111;
        rdy   = 1'b1;
        cycle("rst0");
        cycle("rst1");
        check_eq("rst.o_valid", 32'(o_valid), 32'd0);
        check_eq("rst.o_data",  32'(o_data),  32'd0);

        // Manual select of channel 2
        rst   = 1'b0;
        ctrl  = 2'd2;
        valid = 4'b0100;
        data  = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        cycle("man");
        check_eq("man.o_data", 32'(o_data), 32'h0000BEEF);
        check_eq("man.o_chan", 32'(o_chan), 32'd2);

        // Round-robin from a fresh reset: 0,1,2,3,0,1,2,3
        rst = 1'b1;
        cycle("rst2");
        rst   = 1'b0;
        mode  = MODE_RR;
        valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            data = {$urandom, $urandom};
            cycle("rr4");
            check_eq("rr4.seq", 32'(o_chan), 32'(i % 4));
            check_eq("rr4.ov",  32'(o_valid), 32'd1);
        end

        // Backpressure: held beat stays stable while channel data changes
        rdy  = 1'b0;
        held = o_data;
        for (int i = 0; i < 3; i++) begin
            data = {$urandom, $urandom};
            cycle("bp");
            check_eq("bp.stable", 32'(o_data), 32'(held));
        end
        rdy = 1'b1;
        cycle("bp_rel");

        // Sparse round-robin: park last at 1 via a manual accept, then 1001 -> 3,0,3
        mode  = MODE_MANUAL;
        ctrl  = 2'd1;
        valid = 4'b0010;
        cycle("park");
        mode  = MODE_RR;
        valid = 4'b1001;
        cycle("sp0");
        check_eq("sp0.chan", 32'(o_chan), 32'd3);
        cycle("sp1");
        check_eq("sp1.chan", 32'(o_chan), 32'd0);
        cycle("sp2");
        check_eq("sp2.chan", 32'(o_chan), 32'd3);

        // Mid-operation reset with a stalled beat
        rdy = 1'b0;
        cycle("stall");
        rst = 1'b1;
        cycle("mrst");
        check_eq("mrst.o_valid", 32'(o_valid), 32'd0);
        rst   = 1'b0;
        rdy   = 1'b1;
        valid = 4'b0110;
        cycle("post");
        check_eq("post.chan", 32'(o_chan), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            mode  = $urandom_range(0, 1) != 0;
            ctrl  = SEL_W'($urandom_range(0, NCH - 1));
            valid = NCH'($urandom);
            if ($urandom_range(0, 3) == 0) valid = '0;
            rdy   = ($urandom_range(0, 3) != 0);
            data  = {$urandom, $urandom};
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_select_arb.md
DATA_SELECT_ARB -- requirements
Module: data_select_arb

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 Parameter NCH, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NCH), width of channel-index signals.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_mode  input  1  0 = manual select by i_ctrl, 1 = round-robin arbitration.
REQ-007 i_ctrl  input  SEL_W  manual channel select, used only when i_mode=0.
REQ-008 i_data  input  NCH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-009 i_valid  input  NCH  per-channel data-valid.
REQ-010 o_ready  output  NCH  per-channel accept; a beat transfers on channel k when i_valid[k] and o_ready[k] are both 1 at a clock edge.
REQ-011 o_data  output  WIDTH  registered selected data.
REQ-012 o_chan  output  SEL_W  index of the channel that supplied o_data.
REQ-013 o_valid  output  1  o_data/o_chan hold an unconsumed beat.
REQ-014 i_ready  input  1  downstream accept; the output beat is consumed when o_valid and i_ready are both 1.

Function
REQ-015 space = !o_valid || i_ready, combinational; a new beat loads only when space=1.
REQ-016 Grant gnt (SEL_W bits) and gnt_ok are combinational: manual mode gives gnt=i_ctrl, gnt_ok=i_valid[i_ctrl]; round-robin mode gives gnt = first k with i_valid[k]=1, searching last+1, last+2, ... modulo NCH, and gnt_ok = |i_valid.
REQ-017 o_ready[k] = space && gnt_ok && (gnt==k); at most one o_ready bit is 1 per cycle.
REQ-018 i_ctrl >= NCH (non-power-of-two NCH) makes gnt_ok=0; no transfer occurs and o_ready is all zeros.
REQ-019 Accept (space && gnt_ok): next edge loads o_data <= channel gnt data, o_chan <= gnt, o_valid <= 1; latency is one cycle from accept to o_valid.
REQ-020 space && !gnt_ok: next edge sets o_valid <= 0; o_data and o_chan hold their values.
REQ-021 !space (o_valid=1, i_ready=0): o_valid, o_data and o_chan hold; o_ready is all zeros.
REQ-022 Simultaneous output consume and new accept in one cycle: the new beat replaces the old one with no bubble, sustaining 1 beat per cycle.
REQ-023 The round-robin pointer "last" updates to gnt on every accept in either mode; with no accept it holds.
REQ-024 The round-robin search wraps from NCH-1 to 0; a single requesting channel is granted every cycle while space=1.
REQ-025 i_mode and i_ctrl are sampled every cycle; a change affects the grant in the same cycle and never corrupts a held beat.

Reset
REQ-026 While i_rst=1 at an edge: o_valid <= 0, o_data <= 0, o_chan <= 0, last <= NCH-1, so the first round-robin search starts at channel 0.
REQ-027 While i_rst=1, o_ready is all zeros; a held beat is discarded without handshake.
REQ-028 The first accept is possible at the first edge after i_rst deasserts.

Structure
REQ-029 Mode encodings MODE_MANUAL=1'b0 and MODE_RR=1'b1 are defined in the shared constants package data_sel_pkg.
REQ-030 Round-robin search is a combinational sub-module rr_pick (inputs req[NCH], last[SEL_W]; outputs gnt[SEL_W], any); the output register and pointer stay in data_select_arb.
REQ-031 No latches, and no combinational path from i_ready to o_data, o_chan or o_valid.

Verification
REQ-032 Reset: drive i_rst=1 with all i_valid=1 -> o_valid=0, o_data=0, o_chan=0, o_ready=0000.
REQ-033 Manual mode, NCH=4, WIDTH=16: i_ctrl=2, i_valid=0100, channel 2 data 16'hBEEF, i_ready=1 -> o_ready=0100; next cycle o_data=16'hBEEF, o_chan=2, o_valid=1.
REQ-034 Round-robin mode: i_valid=1111 held for 8 cycles, i_ready=1 -> o_chan sequence 0,1,2,3,0,1,2,3 with o_valid=1 every cycle.
REQ-035 Backpressure: beat held with i_ready=0 for 3 cycles while channel data changes -> o_data is stable, o_ready=0000; on i_ready=1, the next beat loads in the same cycle.
REQ-036 Sparse round-robin: last=1, i_valid=1001 -> grant 3, then grant 0, then 3 (wrap-around).
REQ-037 Mid-operation reset: i_rst=1 with o_valid=1 and i_ready=0 -> o_valid=0 next cycle; first round-robin grant after release is the lowest valid channel index.
